mixcolumn: RTL and testbench

MIXCOLUMN -- requirements
Module: mixcolumn

---
 rtl/mixcolumn_if.sv | 13 +
 rtl/mixcolumn.sv | 121 ++++++++++++
 tb/tb_mixcolumn.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mixcolumn_if.sv
// Bus bundle for the AES MixColumns stage: request side (state + mode + start)
// and response side (registered result, completion pulse, busy flag).
interface mixcolumn_if;
  logic [127:0] data_in;
  logic         start_in;
  logic         en_de;
  logic [127:0] data_out;
  logic         ready_out;
  logic         busy;

  modport master (output data_in, start_in, en_de, input data_out, ready_out, busy);
  modport slave  (input data_in, start_in, en_de, output data_out, ready_out, busy);
endinterface

// File: rtl/mixcolumn.sv
// AES (Inv)MixColumns, one column per clock: 1 capture edge + 4 column edges.
// Result bytes keep the row-major layout of the input state.
module mixcolumn_row #(
  parameter int ROW = 0
) (
  input  logic [3:0][7:0] col_a,
  input  logic            enc,
  output logic [7:0]      b
);
  localparam int R1 = (ROW + 1) % 4;
  localparam int R2 = (ROW + 2) % 4;
  localparam int R3 = (ROW + 3) % 4;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Constant multiply as a sum of x, 2x, 4x, 8x selected by the bits of k.
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? x : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  always_comb begin
    if (enc)
      b = gmul(col_a[ROW], 4'h2) ^ gmul(col_a[R1], 4'h3) ^ col_a[R2] ^ col_a[R3];
    else
      b = gmul(col_a[ROW], 4'he) ^ gmul(col_a[R1], 4'hb) ^
          gmul(col_a[R2], 4'hd) ^ gmul(col_a[R3], 4'h9);
  end
endmodule

module mixcolumn #(
  parameter int NUM_LANES = 4
) (
  input  logic        clk,
  input  logic        rst,
  mixcolumn_if.slave  bus
);
  typedef enum logic {IDLE, CALC} state_t;

  state_t state, state_d;
  logic [1:0] col;
  logic       enc_q;
  // [3-r][3-c] maps to byte (r,c) at bits 127-32r-8c.
  logic [3:0][3:0][7:0]      din_q, res_q, res_d;
  logic [NUM_LANES-1:0][7:0] col_a, col_b;

  always_comb begin
    col_a = '0;
    for (int r = 0; r < NUM_LANES; r++)
      col_a[r] = din_q[2'(3 - r)][~col];
  end

  for (genvar r = 0; r < NUM_LANES; r++) begin : g_row
    mixcolumn_row #(.ROW(r)) u_row (
      .col_a (col_a),
      .enc   (enc_q),
      .b     (col_b[r])
    );
  end

  always_comb begin
    res_d = res_q;
    for (int r = 0; r < NUM_LANES; r++)
      res_d[2'(3 - r)][~col] = col_b[r];
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (bus.start_in) state_d = CALC;
      CALC: if (col == 2'd3)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col           <= 2'd0;
      enc_q         <= 1'b0;
      din_q         <= '0;
      res_q         <= '0;
      bus.data_out  <= '0;
      bus.ready_out <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.ready_out <= 1'b0;
      case (state)
        IDLE: if (bus.start_in) begin
          din_q    <= bus.data_in;
          enc_q    <= bus.en_de;
          col      <= 2'd0;
          bus.busy <= 1'b1;
        end
        CALC: begin
          res_q <= res_d;
          // Last column goes straight to data_out so the result lands at E4.
          if (col == 2'd3) begin
            bus.data_out  <= res_d;
            bus.ready_out <= 1'b1;
            bus.busy      <= 1'b0;
            col           <= 2'd0;
          end else begin
            col <= col + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mixcolumn.sv
// Directed bench for mixcolumn: vector table with hand-computed results,
// plus streaming, mid-transform reset and idle sequences.
module tb_mixcolumn;
  logic clk = 1'b0;
  logic rst = 1'b1;
  mixcolumn_if bus();

  mixcolumn u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] din;
    logic         en;
    logic [127:0] exp;
  } vec_t;

  vec_t vt[10];
  int   total  = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // One transform: start at E0, check latency, result, busy and pulse width.
  task automatic run_vec(input vec_t v, input string name);
    @(negedge clk);
    bus.data_in  = v.din;
    bus.en_de    = v.en;
    bus.start_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_in = 1'b0;
    bus.en_de    = ~v.en;
    bus.data_in  = {$urandom(), $urandom(), $urandom(), $urandom()};
    chk({name, " busy_after_start"}, bus.busy, 1'b1);
    for (int k = 1; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk({name, " ready_early"}, bus.ready_out, 1'b0);
    end
    @(posedge clk);
    @(negedge clk);
    chk({name, " ready_E4"}, bus.ready_out, 1'b1);
    chk({name, " data_E4"}, bus.data_out, v.exp);
    chk({name, " busy_E4"}, bus.busy, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk({name, " ready_E5"}, bus.ready_out, 1'b0);
    chk({name, " data_hold"}, bus.data_out, v.exp);
  endtask

  initial begin
    int busy_cnt;
    int sidx[3];

    vt[0] = '{128'hdbdbdbdb_13131313_53535353_45454545, 1'b1, 128'h8e8e8e8e_4d4d4d4d_a1a1a1a1_bcbcbcbc};
    vt[1] = '{128'h8e8e8e8e_4d4d4d4d_a1a1a1a1_bcbcbcbc, 1'b0, 128'hdbdbdbdb_13131313_53535353_45454545};
    vt[2] = '{128'hdbf201c6_130a01c6_532201c6_455c01c6, 1'b1, 128'h8e9f01c6_4ddc01c6_a15801c6_bc9d01c6};
    vt[3] = '{128'h8e9f01c6_4ddc01c6_a15801c6_bc9d01c6, 1'b0, 128'hdbf201c6_130a01c6_532201c6_455c01c6};
    vt[4] = '{128'h01000000_00000000_00000000_00000000, 1'b1, 128'h02000000_01000000_01000000_03000000};
    vt[5] = '{128'h00000001_00000000_00000000_00000000, 1'b0, 128'h0000000e_00000009_0000000d_0000000b};
    vt[6] = '{128'h00800000_00000000_00000000_00000000, 1'b1, 128'h001b0000_00800000_00800000_009b0000};
    vt[7] = '{128'h0, 1'b1, 128'h0};
    vt[8] = '{{128{1'b1}}, 1'b0, {128{1'b1}}};
    vt[9] = '{128'h01010101_01010101_01010101_01010101, 1'b1, 128'h01010101_01010101_01010101_01010101};

    bus.data_in  = 128'h0123456789abcdef_fedcba9876543210;
    bus.en_de    = 1'b1;
    bus.start_in = 1'b1;

    // Reset state, with start asserted to show it is ignored under reset.
    @(posedge clk);
    @(negedge clk);
    chk("rst data_out", bus.data_out, 128'h0);
    chk("rst ready", bus.ready_out, 1'b0);
    chk("rst busy", bus.busy, 1'b0);
    bus.start_in = 1'b0;
    rst = 1'b0;

    // Idle for 20 cycles: nothing moves.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle flags", {bus.busy, bus.ready_out}, 2'b00);
      chk("idle data_out", bus.data_out, 128'h0);
    end

    foreach (vt[i]) run_vec(vt[i], $sformatf("vec%0d", i));

    // Start held high, data/mode scrambled every non-start cycle.
    sidx = '{0, 3, 6};
    busy_cnt = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      bus.start_in = 1'b1;
      if (cyc % 5 == 0) begin
        bus.data_in = vt[sidx[cyc / 5]].din;
        bus.en_de   = vt[sidx[cyc / 5]].en;
      end else begin
        bus.data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.en_de   = 1'($urandom());
      end
      @(posedge clk);
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      chk("stream ready", bus.ready_out, (cyc % 5 == 4) ? 1'b1 : 1'b0);
      chk("stream busy", bus.busy, (cyc % 5 == 4) ? 1'b0 : 1'b1);
      if (cyc % 5 == 4) chk("stream data", bus.data_out, vt[sidx[cyc / 5]].exp);
    end
    bus.start_in = 1'b0;
    chk("stream busy cycles", 128'(busy_cnt), 128'd12);

    // Reset in the cycle after E2 aborts the transform with no pulse.
    @(negedge clk);
    bus.data_in  = vt[2].din;
    bus.en_de    = 1'b1;
    bus.start_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_in = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst data_out", bus.data_out, 128'h0);
    chk("midrst flags", {bus.busy, bus.ready_out}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("postrst ready", bus.ready_out, 1'b0);
      chk("postrst data_out", bus.data_out, 128'h0);
    end
    run_vec(vt[0], "after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
